// File: rtl/pwm_bus_arbiter.sv
// Round-robin arbiter between the I2C bridge (port A) and the duty-update
// engine (port B) in front of the PWM register file. It runs one transaction
// at a time, reads with a fixed latency, and returns a one-cycle ack to the
// port that won the bus.
module pwm_bus_arbiter #(
  parameter int WIDTH  = 16,
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk_psc_i,
  input  logic             rst_n_i,
  input  logic             a_req_i,
  input  logic             a_wr_i,
  input  logic [AW-1:0]    a_addr_i,
  input  logic [WIDTH-1:0] a_wdata_i,
  output logic             a_ack_o,
  output logic [WIDTH-1:0] a_rdata_o,
  input  logic             b_req_i,
  input  logic             b_wr_i,
  input  logic [AW-1:0]    b_addr_i,
  input  logic [WIDTH-1:0] b_wdata_i,
  output logic             b_ack_o,
  output logic [WIDTH-1:0] b_rdata_o,
  output logic             wr_en_o,
  output logic             rd_en_o,
  output logic [AW-1:0]    addr_o,
  output logic [WIDTH-1:0] wdata_o,
  input  logic [WIDTH-1:0] rdata_i,
  output logic [1:0]       gnt_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  state_e           state_q;
  logic             wr_q;
  logic             last_b_q;   // 1 when B owned the previous transaction
  logic [2:0]       cnt_q;
  logic [1:0]       gnt_q;
  logic             busy_q;
  logic             wr_en_q;
  logic             rd_en_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             a_ack_q;
  logic             b_ack_q;
  logic [WIDTH-1:0] a_rdata_q;
  logic [WIDTH-1:0] b_rdata_q;

  logic             pick_b_d;
  logic             sel_wr_d;
  logic [AW-1:0]    sel_addr_d;
  logic [WIDTH-1:0] sel_wdata_d;

  // Winner selection: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    pick_b_d    = 1'b0;
    sel_wr_d    = a_wr_i;
    sel_addr_d  = a_addr_i;
    sel_wdata_d = a_wdata_i;
    if (a_req_i && b_req_i) begin
      pick_b_d = ~last_b_q;
    end else if (b_req_i) begin
      pick_b_d = 1'b1;
    end else begin
      pick_b_d = 1'b0;
    end
    if (pick_b_d) begin
      sel_wr_d    = b_wr_i;
      sel_addr_d  = b_addr_i;
      sel_wdata_d = b_wdata_i;
    end else begin
      sel_wr_d    = a_wr_i;
      sel_addr_d  = a_addr_i;
      sel_wdata_d = a_wdata_i;
    end
  end

  // Transaction sequencer with all bus and port outputs registered.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      wr_q      <= 1'b0;
      last_b_q  <= 1'b1;
      cnt_q     <= 3'd0;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (a_req_i || b_req_i) begin
            gnt_q   <= pick_b_d ? 2'b10 : 2'b01;
            wr_q    <= sel_wr_d;
            addr_q  <= sel_addr_d;
            wdata_q <= sel_wdata_d;
            wr_en_q <= sel_wr_d;
            rd_en_q <= ~sel_wr_d;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          wr_en_q <= 1'b0;
          rd_en_q <= 1'b0;
          if (wr_q) begin
            a_ack_q <= gnt_q[0];
            b_ack_q <= gnt_q[1];
            state_q <= ST_ACK;
          end else begin
            cnt_q   <= 3'(RD_LAT);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The last wait cycle is the one where the register file data is valid.
          if (cnt_q <= 3'd1) begin
            if (gnt_q[1]) begin
              b_rdata_q <= rdata_i;
            end else begin
              a_rdata_q <= rdata_i;
            end
            a_ack_q <= gnt_q[0];
            b_ack_q <= gnt_q[1];
            cnt_q   <= 3'd0;
            state_q <= ST_ACK;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_ACK: begin
          a_ack_q  <= 1'b0;
          b_ack_q  <= 1'b0;
          last_b_q <= gnt_q[1];
          gnt_q    <= 2'b00;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          wr_en_q <= 1'b0;
          rd_en_q <= 1'b0;
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_ack_o   = a_ack_q;
  assign b_ack_o   = b_ack_q;
  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;
  assign wr_en_o   = wr_en_q;
  assign rd_en_o   = rd_en_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign gnt_o     = gnt_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_pwm_bus_arbiter.sv
// Scoreboard bench for pwm_bus_arbiter: one instance with RD_LAT=1 for the
// arbitration/write/read scenarios, one with RD_LAT=3 for the long read.
module tb_pwm_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // RD_LAT = 1 instance signals
  logic        a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
  logic [7:0]  a_addr = 8'h00, b_addr = 8'h00;
  logic [15:0] a_wdata = 16'h0000, b_wdata = 16'h0000;
  logic        a_ack, b_ack, wr_en, rd_en, busy;
  logic [15:0] a_rdata, b_rdata, wdata, rdata;
  logic [7:0]  addr;
  logic [1:0]  gnt;
  logic        rd_pipe = 1'b0;

  // RD_LAT = 3 instance signals
  logic        a3_req = 1'b0;
  logic        a3_ack, b3_ack, wr3, rd3, busy3;
  logic [15:0] a3_rdata, b3_rdata, wdata3, rdata3;
  logic [7:0]  addr3;
  logic [1:0]  gnt3;
  logic [2:0]  pipe3 = 3'b000;

  pwm_bus_arbiter #(.WIDTH(16), .AW(8), .RD_LAT(1)) u_dut (
    .clk_psc_i(clk), .rst_n_i(rst_n),
    .a_req_i(a_req), .a_wr_i(a_wr), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_ack_o(a_ack), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_wr_i(b_wr), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_ack_o(b_ack), .b_rdata_o(b_rdata),
    .wr_en_o(wr_en), .rd_en_o(rd_en), .addr_o(addr), .wdata_o(wdata),
    .rdata_i(rdata), .gnt_o(gnt), .busy_o(busy)
  );

  pwm_bus_arbiter #(.WIDTH(16), .AW(8), .RD_LAT(3)) u_dut3 (
    .clk_psc_i(clk), .rst_n_i(rst_n),
    .a_req_i(a3_req), .a_wr_i(1'b0), .a_addr_i(8'h10), .a_wdata_i(16'h0000),
    .a_ack_o(a3_ack), .a_rdata_o(a3_rdata),
    .b_req_i(1'b0), .b_wr_i(1'b0), .b_addr_i(8'h00), .b_wdata_i(16'h0000),
    .b_ack_o(b3_ack), .b_rdata_o(b3_rdata),
    .wr_en_o(wr3), .rd_en_o(rd3), .addr_o(addr3), .wdata_o(wdata3),
    .rdata_i(rdata3), .gnt_o(gnt3), .busy_o(busy3)
  );

  // Register-file models: data valid only in the RD_LAT-th cycle after rd_en.
  always @(posedge clk) begin
    rd_pipe <= rd_en;
    pipe3   <= {pipe3[1:0], rd3};
  end
  assign rdata  = rd_pipe ? ((addr == 8'h04) ? 16'hBEEF : 16'h0000) : 16'hDEAD;
  assign rdata3 = pipe3[2] ? 16'h1234 : 16'hDEAD;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic        port;   // 0 = A, 1 = B
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  logic pend_valid = 1'b0;
  int   pend_cyc = 0;
  int   strobe_cycs[$];

  // Bus/ack monitor for the RD_LAT=1 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en || rd_en) begin
        chk_eq("strobe_exclusive", {31'd0, wr_en & rd_en}, 32'd0);
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          pend = exp_q.pop_front();
          chk_eq("bus_wr", {31'd0, wr_en}, {31'd0, pend.wr});
          chk_eq("bus_addr", {24'd0, addr}, {24'd0, pend.addr});
          if (pend.wr) chk_eq("bus_wdata", {16'd0, wdata}, {16'd0, pend.wdata});
          chk_eq("bus_gnt", {30'd0, gnt}, pend.port ? 32'd2 : 32'd1);
          chk_eq("bus_busy", {31'd0, busy}, 32'd1);
          pend_valid = 1'b1;
          pend_cyc   = cyc;
          strobe_cycs.push_back(cyc);
        end
      end
      if (a_ack || b_ack) begin
        if (!pend_valid) begin
          chk_eq("unexpected_ack", 32'd1, 32'd0);
        end else begin
          chk_eq("ack_port", {30'd0, b_ack, a_ack}, pend.port ? 32'd2 : 32'd1);
          chk_eq("ack_latency", cyc - pend_cyc, pend.wr ? 32'd1 : 32'd2);
          chk_eq("ack_gnt", {30'd0, gnt}, pend.port ? 32'd2 : 32'd1);
          if (!pend.wr)
            chk_eq("ack_rdata", {16'd0, pend.port ? b_rdata : a_rdata}, {16'd0, pend.rdata});
          pend_valid = 1'b0;
        end
      end
    end
  end

  task automatic push_exp(input logic port, input logic wr, input logic [7:0] ad,
                          input logic [15:0] wd, input logic [15:0] rd);
    exp_t e;
    e.port = port; e.wr = wr; e.addr = ad; e.wdata = wd; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Holds a request for n back-to-back transactions, then drops it.
  task automatic port_run(input logic port, input logic wr, input logic [7:0] ad,
                          input logic [15:0] wd, input int n);
    if (port) begin
      b_wr = wr; b_addr = ad; b_wdata = wd; b_req = 1'b1;
    end else begin
      a_wr = wr; a_addr = ad; a_wdata = wd; a_req = 1'b1;
    end
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      while (t < 60) begin
        @(negedge clk);
        if (port ? b_ack : a_ack) break;
        t++;
      end
      if (t >= 60) chk_eq(port ? "b_ack_timeout" : "a_ack_timeout", 32'd1, 32'd0);
    end
    if (port) b_req = 1'b0;
    else a_req = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    chk_eq({tag, "_strobes_acks"}, {28'd0, wr_en, rd_en, a_ack, b_ack}, 32'd0);
    chk_eq({tag, "_gnt_busy"}, {29'd0, gnt, busy}, 32'd0);
    chk_eq({tag, "_addr_wdata"}, {8'd0, addr, wdata}, 32'd0);
    chk_eq({tag, "_rdata"}, {a_rdata, b_rdata}, 32'd0);
  endtask

  task automatic settle_and_check_empty(input string tag);
    repeat (3) @(negedge clk);
    chk_eq({tag, "_scoreboard_empty"}, {31'd0, pend_valid} + exp_q.size(), 32'd0);
  endtask

  initial begin
    int s3, seen;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    chk_eq("reset_dut3", {27'd0, wr3, rd3, a3_ack, gnt3 == 2'b00, busy3}, 32'd2);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie straight after reset: A first, then B.
    push_exp(1'b0, 1'b1, 8'h05, 16'h0006, 16'h0000);
    push_exp(1'b1, 1'b1, 8'h06, 16'h0007, 16'h0000);
    strobe_cycs.delete();
    fork
      port_run(1'b0, 1'b1, 8'h05, 16'h0006, 1);
      port_run(1'b1, 1'b1, 8'h06, 16'h0007, 1);
    join
    settle_and_check_empty("tie");
    chk_eq("tie_strobe_count", strobe_cycs.size(), 32'd2);
    if (strobe_cycs.size() == 2) chk_eq("tie_spacing", strobe_cycs[1] - strobe_cycs[0], 32'd3);

    // Single write from A, B idle.
    push_exp(1'b0, 1'b1, 8'h03, 16'h0001, 16'h0000);
    port_run(1'b0, 1'b1, 8'h03, 16'h0001, 1);
    settle_and_check_empty("write_a");
    chk_eq("write_a_bus_held", {8'd0, addr, wdata}, 32'h0003_0001);

    // Single read from B.
    push_exp(1'b1, 1'b0, 8'h04, 16'h0000, 16'hBEEF);
    port_run(1'b1, 1'b0, 8'h04, 16'h0000, 1);
    settle_and_check_empty("read_b");
    chk_eq("read_b_rdata_held", {16'd0, b_rdata}, 32'h0000_BEEF);
    chk_eq("read_b_a_rdata_zero", {16'd0, a_rdata}, 32'd0);

    // Continuous contention: four writes each, strict alternation.
    for (int k = 0; k < 4; k++) begin
      push_exp(1'b0, 1'b1, 8'h20, 16'hA5A5, 16'h0000);
      push_exp(1'b1, 1'b1, 8'h30, 16'h5A5A, 16'h0000);
    end
    strobe_cycs.delete();
    fork
      port_run(1'b0, 1'b1, 8'h20, 16'hA5A5, 4);
      port_run(1'b1, 1'b1, 8'h30, 16'h5A5A, 4);
    join
    settle_and_check_empty("contention");
    chk_eq("contention_strobe_count", strobe_cycs.size(), 32'd8);
    for (int k = 1; k < strobe_cycs.size(); k++)
      chk_eq("contention_spacing", strobe_cycs[k] - strobe_cycs[k-1], 32'd3);

    // RD_LAT=3 read on the second instance.
    a3_req = 1'b1;
    s3 = -1;
    seen = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (rd3) begin
        s3 = cyc;
        chk_eq("lat3_addr", {24'd0, addr3}, 32'h10);
      end
      if (a3_ack) begin
        seen = 1;
        a3_req = 1'b0;
        chk_eq("lat3_ack_cycle", cyc - s3, 32'd4);
        chk_eq("lat3_rdata", {16'd0, a3_rdata}, 32'h1234);
        break;
      end
    end
    a3_req = 1'b0;
    chk_eq("lat3_ack_seen", seen, 32'd1);

    // Reset during the WAIT cycle of a B read.
    push_exp(1'b1, 1'b0, 8'h04, 16'h0000, 16'hBEEF);
    b_wr = 1'b0; b_addr = 8'h04; b_wdata = 16'h0000; b_req = 1'b1;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (rd_en) seen = 1;
    end
    chk_eq("rst_read_strobe_seen", seen, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    b_req = 1'b0;
    #1;
    check_reset_outs("midreset");
    pend_valid = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (b_ack) seen++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (b_ack) seen++;
    end
    chk_eq("midreset_no_b_ack", seen, 32'd0);

    // After reset A again wins the tie.
    push_exp(1'b0, 1'b1, 8'h07, 16'h0008, 16'h0000);
    push_exp(1'b1, 1'b1, 8'h08, 16'h0009, 16'h0000);
    fork
      port_run(1'b0, 1'b1, 8'h07, 16'h0008, 1);
      port_run(1'b1, 1'b1, 8'h08, 16'h0009, 1);
    join
    settle_and_check_empty("post_reset_tie");
    chk_eq("post_reset_b_rdata", {16'd0, b_rdata}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
